// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline controller (master) and the datapath-side
// control registers (slave): stage clear/enable, ID decode fields in,
// stage-valid flags, per-stage feedback and performance counters out.
//
// Stage valid semantics: a stage register loads only on X_en, clears on X_rst
// (clear wins), otherwise holds. X_valid = 1 means the stage holds a real
// instruction; every enable-type feedback output is qualified by it.
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  // stage control from the controller
  logic             if_rst, id_rst, exe_rst, mem_rst, wb_rst;
  logic             if_en, id_en, exe_en, mem_en, wb_en;
  // ID-stage decode fields
  logic [2:0]       pc_src;
  logic [1:0]       exe_a_src, exe_b_src;
  logic [3:0]       exe_alu_oper;
  logic [1:0]       exe_fwd_a, exe_fwd_b;
  logic             mem_ren, mem_wen, wb_data_src, wb_wen;
  logic [4:0]       regw_addr_id;
  // stage status and feedback
  logic             if_valid, id_valid, exe_valid, mem_valid, wb_valid;
  logic [1:0]       exe_a_src_exe, exe_b_src_exe, exe_fwd_a_exe, exe_fwd_b_exe;
  logic [3:0]       exe_alu_oper_exe;
  logic             is_branch_exe, is_branch_mem;
  logic [4:0]       regw_addr_exe, regw_addr_mem, regw_addr_wb;
  logic             wb_wen_exe, wb_wen_mem, wb_wen_wb;
  logic             mem_ren_exe, mem_ren_mem;
  logic             mem_wen_mem;
  logic             wb_data_src_wb;
  logic [CNT_W-1:0] retired_cnt, bubble_cnt;

  modport master (
    output if_rst, id_rst, exe_rst, mem_rst, wb_rst,
    output if_en, id_en, exe_en, mem_en, wb_en,
    output pc_src, exe_a_src, exe_b_src, exe_alu_oper, exe_fwd_a, exe_fwd_b,
    output mem_ren, mem_wen, wb_data_src, wb_wen, regw_addr_id,
    input  if_valid, id_valid, exe_valid, mem_valid, wb_valid,
    input  exe_a_src_exe, exe_b_src_exe, exe_fwd_a_exe, exe_fwd_b_exe,
    input  exe_alu_oper_exe, is_branch_exe, is_branch_mem,
    input  regw_addr_exe, regw_addr_mem, regw_addr_wb,
    input  wb_wen_exe, wb_wen_mem, wb_wen_wb, mem_ren_exe, mem_ren_mem,
    input  mem_wen_mem, wb_data_src_wb, retired_cnt, bubble_cnt
  );

  modport slave (
    input  if_rst, id_rst, exe_rst, mem_rst, wb_rst,
    input  if_en, id_en, exe_en, mem_en, wb_en,
    input  pc_src, exe_a_src, exe_b_src, exe_alu_oper, exe_fwd_a, exe_fwd_b,
    input  mem_ren, mem_wen, wb_data_src, wb_wen, regw_addr_id,
    output if_valid, id_valid, exe_valid, mem_valid, wb_valid,
    output exe_a_src_exe, exe_b_src_exe, exe_fwd_a_exe, exe_fwd_b_exe,
    output exe_alu_oper_exe, is_branch_exe, is_branch_mem,
    output regw_addr_exe, regw_addr_mem, regw_addr_wb,
    output wb_wen_exe, wb_wen_mem, wb_wen_wb, mem_ren_exe, mem_ren_mem,
    output mem_wen_mem, wb_data_src_wb, retired_cnt, bubble_cnt
  );
endinterface

// File: rtl/pipe_ctrl_regs.sv
// Datapath-side control pipeline: carries ID decode fields through
// EXE/MEM/WB under per-stage clear/enable, reports stage valids and the
// feedback the controller uses for stalls, flushes and forwarding, and
// counts retired instructions and inserted bubbles.
module pipe_ctrl_regs #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  localparam logic [2:0] PC_NEXT = 3'b000;

  // IF / ID: only the valid flag lives here; decode fields arrive live at ID
  logic             if_valid_q, id_valid_q;

  // EXE stage register
  logic             exe_valid_q;
  logic [2:0]       exe_pc_src_q;
  logic [1:0]       exe_a_src_q, exe_b_src_q, exe_fwd_a_q, exe_fwd_b_q;
  logic [3:0]       exe_alu_oper_q;
  logic             exe_mem_ren_q, exe_mem_wen_q, exe_wb_data_src_q, exe_wb_wen_q;
  logic [4:0]       exe_regw_addr_q;

  // MEM stage register
  logic             mem_valid_q;
  logic [2:0]       mem_pc_src_q;
  logic             mem_mem_ren_q, mem_mem_wen_q, mem_wb_data_src_q, mem_wb_wen_q;
  logic [4:0]       mem_regw_addr_q;

  // WB stage register
  logic             wb_valid_q;
  logic             wb_wb_data_src_q, wb_wb_wen_q;
  logic [4:0]       wb_regw_addr_q;

  // performance counters
  logic [CNT_W-1:0] retired_cnt_q, bubble_cnt_q;

  // IF: fetch always yields an instruction once enabled
  always_ff @(posedge clk) begin
    if (rst || bus.if_rst) begin
      if_valid_q <= 1'b0;
    end else if (bus.if_en) begin
      if_valid_q <= 1'b1;
    end
  end

  // ID: inherits the IF valid flag
  always_ff @(posedge clk) begin
    if (rst || bus.id_rst) begin
      id_valid_q <= 1'b0;
    end else if (bus.id_en) begin
      id_valid_q <= if_valid_q;
    end
  end

  // EXE: capture decode fields, zeroed for a bubble so nothing downstream acts
  always_ff @(posedge clk) begin
    if (rst || bus.exe_rst) begin
      exe_valid_q       <= 1'b0;
      exe_pc_src_q      <= '0;
      exe_a_src_q       <= '0;
      exe_b_src_q       <= '0;
      exe_alu_oper_q    <= '0;
      exe_fwd_a_q       <= '0;
      exe_fwd_b_q       <= '0;
      exe_mem_ren_q     <= 1'b0;
      exe_mem_wen_q     <= 1'b0;
      exe_wb_data_src_q <= 1'b0;
      exe_wb_wen_q      <= 1'b0;
      exe_regw_addr_q   <= '0;
    end else if (bus.exe_en) begin
      exe_valid_q       <= id_valid_q;
      exe_pc_src_q      <= id_valid_q ? bus.pc_src       : '0;
      exe_a_src_q       <= id_valid_q ? bus.exe_a_src    : '0;
      exe_b_src_q       <= id_valid_q ? bus.exe_b_src    : '0;
      exe_alu_oper_q    <= id_valid_q ? bus.exe_alu_oper : '0;
      exe_fwd_a_q       <= id_valid_q ? bus.exe_fwd_a    : '0;
      exe_fwd_b_q       <= id_valid_q ? bus.exe_fwd_b    : '0;
      exe_mem_ren_q     <= id_valid_q & bus.mem_ren;
      exe_mem_wen_q     <= id_valid_q & bus.mem_wen;
      exe_wb_data_src_q <= id_valid_q & bus.wb_data_src;
      exe_wb_wen_q      <= id_valid_q & bus.wb_wen;
      exe_regw_addr_q   <= id_valid_q ? bus.regw_addr_id : '0;
    end
  end

  // MEM: forward the fields still needed past EXE
  always_ff @(posedge clk) begin
    if (rst || bus.mem_rst) begin
      mem_valid_q       <= 1'b0;
      mem_pc_src_q      <= '0;
      mem_mem_ren_q     <= 1'b0;
      mem_mem_wen_q     <= 1'b0;
      mem_wb_data_src_q <= 1'b0;
      mem_wb_wen_q      <= 1'b0;
      mem_regw_addr_q   <= '0;
    end else if (bus.mem_en) begin
      mem_valid_q       <= exe_valid_q;
      mem_pc_src_q      <= exe_pc_src_q;
      mem_mem_ren_q     <= exe_mem_ren_q;
      mem_mem_wen_q     <= exe_mem_wen_q;
      mem_wb_data_src_q <= exe_wb_data_src_q;
      mem_wb_wen_q      <= exe_wb_wen_q;
      mem_regw_addr_q   <= exe_regw_addr_q;
    end
  end

  // WB: register write-back controls
  always_ff @(posedge clk) begin
    if (rst || bus.wb_rst) begin
      wb_valid_q       <= 1'b0;
      wb_wb_data_src_q <= 1'b0;
      wb_wb_wen_q      <= 1'b0;
      wb_regw_addr_q   <= '0;
    end else if (bus.wb_en) begin
      wb_valid_q       <= mem_valid_q;
      wb_wb_data_src_q <= mem_wb_data_src_q;
      wb_wb_wen_q      <= mem_wb_wen_q;
      wb_regw_addr_q   <= mem_regw_addr_q;
    end
  end

  // retired: a real instruction moves from MEM into WB on this edge
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt_q <= '0;
    end else if (!bus.wb_rst && bus.wb_en && mem_valid_q) begin
      retired_cnt_q <= retired_cnt_q + 1'b1;
    end
  end

  // bubbles: every EXE clear outside a global reset inserts one
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= '0;
    end else if (bus.exe_rst) begin
      bubble_cnt_q <= bubble_cnt_q + 1'b1;
    end
  end

  // outputs: raw registers, enable-type flags qualified by the stage valid
  assign bus.if_valid         = if_valid_q;
  assign bus.id_valid         = id_valid_q;
  assign bus.exe_valid        = exe_valid_q;
  assign bus.mem_valid        = mem_valid_q;
  assign bus.wb_valid         = wb_valid_q;

  assign bus.exe_a_src_exe    = exe_a_src_q;
  assign bus.exe_b_src_exe    = exe_b_src_q;
  assign bus.exe_fwd_a_exe    = exe_fwd_a_q;
  assign bus.exe_fwd_b_exe    = exe_fwd_b_q;
  assign bus.exe_alu_oper_exe = exe_alu_oper_q;

  assign bus.is_branch_exe    = exe_valid_q && (exe_pc_src_q != PC_NEXT);
  assign bus.is_branch_mem    = mem_valid_q && (mem_pc_src_q != PC_NEXT);

  assign bus.regw_addr_exe    = exe_regw_addr_q;
  assign bus.regw_addr_mem    = mem_regw_addr_q;
  assign bus.regw_addr_wb     = wb_regw_addr_q;

  assign bus.wb_wen_exe       = exe_valid_q & exe_wb_wen_q;
  assign bus.wb_wen_mem       = mem_valid_q & mem_wb_wen_q;
  assign bus.wb_wen_wb        = wb_valid_q & wb_wb_wen_q;
  assign bus.mem_ren_exe      = exe_valid_q & exe_mem_ren_q;
  assign bus.mem_ren_mem      = mem_valid_q & mem_mem_ren_q;
  assign bus.mem_wen_mem      = mem_valid_q & mem_mem_wen_q;
  assign bus.wb_data_src_wb   = wb_wb_data_src_q;

  assign bus.retired_cnt      = retired_cnt_q;
  assign bus.bubble_cnt       = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_regs.sv
// Randomized and directed bench for pipe_ctrl_regs. A token-per-stage model
// shifts whole instructions through the pipeline and predicts every output.
module tb_pipe_ctrl_regs;

  localparam int CNT_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();
  pipe_ctrl_regs #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // ---------------- model types ----------------
  typedef struct packed {
    logic       valid;
    logic [2:0] pc_src;
    logic [1:0] a_src, b_src;
    logic [3:0] alu;
    logic [1:0] fa, fb;
    logic       mren, mwen, wbds, wbwen;
    logic [4:0] addr;
  } tok_t;

  typedef struct packed {
    logic [4:0]       valids;
    logic [11:0]      exe_f;
    logic [8:0]       flags;
    logic [14:0]      addrs;
    logic [CNT_W-1:0] ret;
    logic [CNT_W-1:0] bub;
  } snap_t;

  localparam int SNAP_W = $bits(snap_t);

  logic             m_if, m_id;
  tok_t             m_exe, m_mem, m_wb;
  logic [CNT_W-1:0] m_ret, m_bub;

  logic [SNAP_W-1:0] exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- checker ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // bit order for both vectors: {if, id, exe, mem, wb}
  task automatic set_ctl(input logic [4:0] rsts, input logic [4:0] ens);
    {bus.if_rst, bus.id_rst, bus.exe_rst, bus.mem_rst, bus.wb_rst} = rsts;
    {bus.if_en, bus.id_en, bus.exe_en, bus.mem_en, bus.wb_en}      = ens;
  endtask

  task automatic set_decode(input logic [2:0] pc, input logic [1:0] as, input logic [1:0] bs,
                            input logic [3:0] alu, input logic [1:0] fa, input logic [1:0] fb,
                            input logic mren, input logic mwen, input logic wbds,
                            input logic wbwen, input logic [4:0] addr);
    bus.pc_src       = pc;
    bus.exe_a_src    = as;
    bus.exe_b_src    = bs;
    bus.exe_alu_oper = alu;
    bus.exe_fwd_a    = fa;
    bus.exe_fwd_b    = fb;
    bus.mem_ren      = mren;
    bus.mem_wen      = mwen;
    bus.wb_data_src  = wbds;
    bus.wb_wen       = wbwen;
    bus.regw_addr_id = addr;
  endtask

  task automatic rand_decode();
    logic [2:0] pc;
    pc = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
    set_decode(pc, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
  endtask

  task automatic rand_ctl();
    logic [4:0] r, e;
    for (int i = 0; i < 5; i++) begin
      r[i] = ($urandom_range(0, 7) == 0);
      e[i] = ($urandom_range(0, 3) != 0);
    end
    set_ctl(r, e);
    rst = ($urandom_range(0, 63) == 0);
  endtask

  // ---------------- reference model ----------------
  function automatic tok_t advance(tok_t cur, tok_t up, logic clr, logic en);
    if (clr) return '0;
    if (en) return up;
    return cur;
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.valids = {m_if, m_id, m_exe.valid, m_mem.valid, m_wb.valid};
    s.exe_f  = {m_exe.a_src, m_exe.b_src, m_exe.fa, m_exe.fb, m_exe.alu};
    s.flags  = {m_exe.valid && m_exe.pc_src != 3'b000,
                m_mem.valid && m_mem.pc_src != 3'b000,
                m_exe.valid && m_exe.wbwen, m_mem.valid && m_mem.wbwen,
                m_wb.valid && m_wb.wbwen,
                m_exe.valid && m_exe.mren, m_mem.valid && m_mem.mren,
                m_mem.valid && m_mem.mwen, m_wb.wbds};
    s.addrs  = {m_exe.addr, m_mem.addr, m_wb.addr};
    s.ret    = m_ret;
    s.bub    = m_bub;
    return s;
  endfunction

  function automatic snap_t dut_snap();
    snap_t s;
    s.valids = {bus.if_valid, bus.id_valid, bus.exe_valid, bus.mem_valid, bus.wb_valid};
    s.exe_f  = {bus.exe_a_src_exe, bus.exe_b_src_exe, bus.exe_fwd_a_exe, bus.exe_fwd_b_exe,
                bus.exe_alu_oper_exe};
    s.flags  = {bus.is_branch_exe, bus.is_branch_mem, bus.wb_wen_exe, bus.wb_wen_mem,
                bus.wb_wen_wb, bus.mem_ren_exe, bus.mem_ren_mem, bus.mem_wen_mem,
                bus.wb_data_src_wb};
    s.addrs  = {bus.regw_addr_exe, bus.regw_addr_mem, bus.regw_addr_wb};
    s.ret    = bus.retired_cnt;
    s.bub    = bus.bubble_cnt;
    return s;
  endfunction

  // one clock edge worth of pipeline movement, using the inputs at that edge
  task automatic model_step();
    tok_t id_tok;
    id_tok = '0;
    if (m_id) begin
      id_tok = '{valid: 1'b1, pc_src: bus.pc_src, a_src: bus.exe_a_src, b_src: bus.exe_b_src,
                 alu: bus.exe_alu_oper, fa: bus.exe_fwd_a, fb: bus.exe_fwd_b,
                 mren: bus.mem_ren, mwen: bus.mem_wen, wbds: bus.wb_data_src,
                 wbwen: bus.wb_wen, addr: bus.regw_addr_id};
    end
    if (rst) begin
      m_if = 1'b0; m_id = 1'b0;
      m_exe = '0; m_mem = '0; m_wb = '0;
      m_ret = '0; m_bub = '0;
    end else begin
      if (!bus.wb_rst && bus.wb_en && m_mem.valid) m_ret = m_ret + 1'b1;
      if (bus.exe_rst) m_bub = m_bub + 1'b1;
      m_wb  = advance(m_wb, m_mem, bus.wb_rst, bus.wb_en);
      m_mem = advance(m_mem, m_exe, bus.mem_rst, bus.mem_en);
      m_exe = advance(m_exe, id_tok, bus.exe_rst, bus.exe_en);
      m_id  = bus.id_rst ? 1'b0 : (bus.id_en ? m_if : m_id);
      m_if  = bus.if_rst ? 1'b0 : (bus.if_en ? 1'b1 : m_if);
    end
    exp_q.push_back(model_snap());
  endtask

  // ---------------- scoreboard ----------------
  task automatic compare_outputs();
    snap_t e, o;
    o = dut_snap();
    if (exp_q.size() == 0) begin
      check_val("exp_q_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check_val("valids",  32'(o.valids), 32'(e.valids));
    check_val("exe_fld", 32'(o.exe_f),  32'(e.exe_f));
    check_val("flags",   32'(o.flags),  32'(e.flags));
    check_val("addrs",   32'(o.addrs),  32'(e.addrs));
    check_val("retired", 32'(o.ret),    32'(e.ret));
    check_val("bubble",  32'(o.bub),    32'(e.bub));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_outputs();
  endtask

  localparam logic [4:0] ALL = 5'b11111;
  localparam logic [4:0] NONE = 5'b00000;

  // ---------------- stimulus ----------------
  initial begin
    logic [CNT_W-1:0] saved_ret;
    m_if = 1'b0; m_id = 1'b0; m_exe = '0; m_mem = '0; m_wb = '0;
    m_ret = '0; m_bub = '0;

    // reset with random inputs for two cycles
    rst = 1'b1;
    set_ctl(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    rand_decode();
    tick();
    rand_decode();
    tick();
    check_val("rst_valids", 32'({bus.if_valid, bus.id_valid, bus.exe_valid, bus.mem_valid,
                                  bus.wb_valid}), 32'd0);
    check_val("rst_cnts", 32'({bus.retired_cnt, bus.bubble_cnt}), 32'd0);
    check_val("rst_addr", 32'({bus.regw_addr_exe, bus.regw_addr_mem, bus.regw_addr_wb}), 32'd0);

    // release: fill the pipe
    rst = 1'b0;
    set_ctl(NONE, ALL);
    rand_decode();
    tick();
    check_val("fill_if_valid", 32'(bus.if_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      rand_decode();
      tick();
    end
    check_val("fill_wb_valid", 32'(bus.wb_valid), 32'd1);

    // straight flow: ADD into $8
    set_decode(3'b000, 2'd0, 2'd0, 4'd2, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8);
    tick();
    check_val("add_addr_exe", 32'(bus.regw_addr_exe), 32'd8);
    check_val("add_wen_exe",  32'(bus.wb_wen_exe), 32'd1);
    rand_decode();
    tick();
    check_val("add_addr_mem", 32'(bus.regw_addr_mem), 32'd8);
    rand_decode();
    tick();
    check_val("add_addr_wb", 32'(bus.regw_addr_wb), 32'd8);
    check_val("add_wen_wb",  32'(bus.wb_wen_wb), 32'd1);

    // load-use: LW into $9 enters EXE, then one stall cycle
    set_decode(3'b000, 2'd0, 2'd1, 4'd2, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9);
    tick();
    rand_decode();
    set_ctl(5'b00100, 5'b00011);
    tick();
    check_val("stall_exe_valid", 32'(bus.exe_valid), 32'd0);
    check_val("stall_wen_exe",   32'(bus.wb_wen_exe), 32'd0);
    check_val("stall_ren_mem",   32'(bus.mem_ren_mem), 32'd1);
    check_val("stall_addr_mem",  32'(bus.regw_addr_mem), 32'd9);
    check_val("stall_bubble",    32'(bus.bubble_cnt), 32'd1);

    // branch: BEQ then three ID flushes
    set_ctl(NONE, ALL);
    set_decode(3'b010, 2'd0, 2'd0, 4'd6, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    tick();
    check_val("beq_is_branch_exe", 32'(bus.is_branch_exe), 32'd1);
    set_ctl(5'b01000, ALL);
    for (int i = 0; i < 3; i++) begin
      rand_decode();
      tick();
      if (i == 0) check_val("beq_is_branch_mem", 32'(bus.is_branch_mem), 32'd1);
    end

    // debug freeze for five cycles, then resume
    set_ctl(NONE, ALL);
    for (int i = 0; i < 3; i++) begin
      rand_decode();
      tick();
    end
    saved_ret = m_ret;
    set_ctl(NONE, NONE);
    for (int i = 0; i < 5; i++) begin
      rand_decode();
      tick();
    end
    check_val("freeze_retired", 32'(bus.retired_cnt), 32'(saved_ret));
    set_ctl(NONE, ALL);
    for (int i = 0; i < 4; i++) begin
      rand_decode();
      tick();
    end

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_ctl();
      rand_decode();
      tick();
    end
    rst = 1'b0;

    // bubble counter wrap: drive to all-ones, one more bubble wraps to 0
    set_ctl(5'b00100, ALL);
    for (int i = 0; i < 20 && m_bub != {CNT_W{1'b1}}; i++) begin
      rand_decode();
      tick();
    end
    check_val("bub_all_ones", 32'(bus.bubble_cnt), 32'((1 << CNT_W) - 1));
    tick();
    check_val("bub_wrap", 32'(bus.bubble_cnt), 32'd0);

    // reset beats enable with a valid instruction in ID
    set_ctl(NONE, ALL);
    for (int i = 0; i < 3; i++) begin
      rand_decode();
      tick();
    end
    check_val("prio_id_valid", 32'(bus.id_valid), 32'd1);
    set_ctl(5'b00100, ALL);
    set_decode(3'b001, 2'd3, 2'd3, 4'hf, 2'd3, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1, 5'd31);
    tick();
    check_val("prio_exe_valid", 32'(bus.exe_valid), 32'd0);
    check_val("prio_exe_addr",  32'(bus.regw_addr_exe), 32'd0);

    // mid-stream global reset clears everything on one edge
    set_ctl(NONE, ALL);
    rand_decode();
    tick();
    rst = 1'b1;
    rand_decode();
    tick();
    check_val("midrst_valids", 32'({bus.if_valid, bus.id_valid, bus.exe_valid,
                                     bus.mem_valid, bus.wb_valid}), 32'd0);
    check_val("midrst_cnts", 32'({bus.retired_cnt, bus.bubble_cnt}), 32'd0);
    rst = 1'b0;
    tick();

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_regs.md
# pipe_ctrl_regs

Datapath-side control pipeline for the MIPS 5-stage pipelined CPU. Consumes the hazard/stage-control outputs and ID-stage decode fields produced by the pipeline controller. Carries those fields through ID→EXE→MEM→WB registers under per-stage enable/reset. Returns the stage-valid flags and the EXE/MEM/WB feedback signals the controller needs for stalls, branch flushing and forwarding, and keeps retire/bubble performance counters.

## Interface
Parameters:
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  main clock
- rst  in  1  synchronous reset, active-high
- if_rst, id_rst, exe_rst, mem_rst, wb_rst  in  1 each  per-stage clear from controller
- if_en, id_en, exe_en, mem_en, wb_en  in  1 each  per-stage load enable from controller
- pc_src  in  3  ID decode; PC_NEXT = 3'b000
- exe_a_src, exe_b_src  in  2 each  ID decode
- exe_alu_oper  in  4  ID decode
- exe_fwd_a, exe_fwd_b  in  2 each  ID forwarding selects
- mem_ren, mem_wen, wb_data_src, wb_wen  in  1 each  ID decode
- regw_addr_id  in  5  resolved destination register (rd/rt/31)
- if_valid, id_valid, exe_valid, mem_valid, wb_valid  out  1 each  stage holds a real instruction
- exe_a_src_exe, exe_b_src_exe, exe_fwd_a_exe, exe_fwd_b_exe  out  2 each  EXE-stage registered copies
- exe_alu_oper_exe  out  4  EXE-stage ALU op
- is_branch_exe, is_branch_mem  out  1  valid && registered pc_src != PC_NEXT
- regw_addr_exe, regw_addr_mem, regw_addr_wb  out  5  destination per stage
- wb_wen_exe, wb_wen_mem, wb_wen_wb  out  1  valid-qualified write enable
- mem_ren_exe, mem_ren_mem  out  1  valid-qualified load flag
- mem_wen_mem  out  1  valid-qualified store strobe to data memory
- wb_data_src_wb  out  1  WB data select
- retired_cnt  out  CNT_W  instructions entering WB
- bubble_cnt  out  CNT_W  stall bubbles inserted into EXE

## Operation
- Every stage register X updates on posedge clk with priority: X_rst → clear (valid 0, all fields 0); else X_en → load from upstream; else hold.
- if_valid: loads 1 on if_en (fetch always produces an instruction).
- id_valid loads if_valid; exe_valid loads id_valid; mem_valid loads exe_valid; wb_valid loads mem_valid.
- EXE loads all decode inputs; fields are zeroed when id_valid = 0, so a bubble never writes, loads, stores or branches.
- MEM loads from EXE: pc_src, regw_addr, mem_ren, mem_wen, wb_data_src, wb_wen.
- WB loads from MEM: regw_addr, wb_data_src, wb_wen.
- All *_exe/*_mem/*_wb enable-type outputs are ANDed with the stage valid. Address outputs are raw registers.
- Writes to $0 are not filtered here; the controller and register file ignore address 0.
- Stall pattern (if_en=id_en=0, exe_rst=1): IF/ID hold, EXE becomes a bubble, MEM/WB advance.
- Branch flush (id_rst=1, others enabled): ID becomes bubble, IF advances.
- Debug freeze (all en = 0, no rst): every register and counter holds.
- retired_cnt: +1 on a cycle with !wb_rst && wb_en && mem_valid. Wraps modulo 2^CNT_W.
- bubble_cnt: +1 on a cycle with !rst && exe_rst. Wraps modulo 2^CNT_W.
- Counters are cleared only by rst, not by individual stage resets.

## Timing
- All outputs are registered; nothing is combinational from inputs except the valid-qualifying AND on registered values.
- Reset: after a clk edge with rst = 1, every output is 0, including valids, fields and counters.
- Latency: a decode field presented with id_valid=1 and exe_en=1 at edge t appears at EXE after t, MEM after t+1, WB after t+2, provided each stage is enabled.
- rst asserted mid-operation clears all stages on the same edge, with no partial retire.
- Simultaneous X_rst and X_en: reset wins.
- The counter increment condition is sampled on the same edge as the stage load.

## Test plan
- Reset: rst high 2 cycles with random inputs → all outputs 0. Release with all en=1 → if_valid=1 after the 1st edge, wb_valid=1 after the 5th.
- Straight flow: ADD, regw_addr_id=8, wb_wen=1 at ID → regw_addr_exe=8 / wb_wen_exe=1 next cycle, then mem next, then wb; retired_cnt increments once.
- Load-use stall: LW (mem_ren=1, addr 9) in EXE, then 1 cycle of if_en=id_en=0, exe_rst=1 → exe_valid=0, wb_wen_exe=0, mem_ren_mem=1, ID held, bubble_cnt=1.
- Branch flush: BEQ (pc_src=PC_BEQ) with id_rst=1 for 3 cycles → is_branch_exe=1 then is_branch_mem=1; the three following stages invalid with no writes; retired_cnt counts only real instructions.
- Freeze: all en=0 for 5 cycles mid-stream → all outputs and counters unchanged. Resume → stream continues identically.
- Wrap/priority: preload bubble_cnt to all-ones (CNT_W=4 build) plus one exe_rst → 0. exe_rst=exe_en=1 with valid ID → EXE cleared.
